fuzzy_risk_engine: RTL and testbench

- Parametrised, pipelined two-input Mamdani-style fuzzy inference block that maps a rainfall sample and a soil-moisture sample to a risk score.
- Fuzzifies each input with three triangular sets (low/medium/high) and evaluates three same-label AND rules with a run-time selectable AND operator.
- Defuzzifies by weighted average through a sequential restoring divider.
- Sits between the sensor sample front-end and the alarm/threshold logic, with valid/ready handshakes on both sides.

---
 rtl/fuzzy_risk_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_fuzzy_risk_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_risk_engine.sv
// fuzzy_risk_engine
// Two-input Mamdani-style fuzzy inference: rainfall and soil moisture are each
// fuzzified into low/medium/high triangular sets, combined by three same-label
// AND rules (min or product), and defuzzified by a weighted average computed
// with a restoring divider. One sample in flight, valid/ready on both sides.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a sample; capture rain, soil and and_mode on accept
// FUZZ  | register the six triangular memberships
// RULE  | register the three rule strengths (min or product AND)
// ACCUM | register weighted numerator and denominator, seed the divider
// DIV   | one quotient bit per edge for MW edges (fixed latency)
// DONE  | hold risk/no_rule with out_valid until out_ready

module fuzzy_risk_engine #(
    parameter int DW   = 8,
    parameter int MW   = 8,
    parameter int LO_A = 0,
    parameter int LO_B = 20,
    parameter int LO_C = 40,
    parameter int MD_A = 30,
    parameter int MD_B = 50,
    parameter int MD_C = 70,
    parameter int HI_A = 60,
    parameter int HI_B = 80,
    parameter int HI_C = 100,
    parameter int W_LO = 85,
    parameter int W_MD = 170,
    parameter int W_HI = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] rain,
    input  logic [DW-1:0] soil,
    input  logic          and_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] risk,
    output logic          no_rule
);

    // Membership arithmetic width: (v-a)*MAX needs DW+MW bits, plus one spare.
    localparam int WP  = DW + MW + 1;
    localparam int NW  = 2 * MW + 2;
    localparam int DNW = MW + 2;
    localparam int CW  = $clog2(MW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FUZZ  = 3'd1,
        S_RULE  = 3'd2,
        S_ACCUM = 3'd3,
        S_DIV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  rain_q, rain_d, soil_q, soil_d;
    logic           mode_q, mode_d;
    logic [MW-1:0]  rain_lo_q, rain_lo_d, rain_md_q, rain_md_d, rain_hi_q, rain_hi_d;
    logic [MW-1:0]  soil_lo_q, soil_lo_d, soil_md_q, soil_md_d, soil_hi_q, soil_hi_d;
    logic [MW-1:0]  s_lo_q, s_lo_d, s_md_q, s_md_d, s_hi_q, s_hi_d;
    logic [DNW-1:0] den_q, den_d, rem_q, rem_d;
    logic [MW-1:0]  nsh_q, nsh_d, quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  risk_q, risk_d;
    logic           no_rule_q, no_rule_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           div_last;
    logic [NW-1:0]  num;
    logic [DNW:0]   trial;
    logic           qbit;

    // Triangular membership; divisions are by breakpoint constants, floored.
    function automatic logic [MW-1:0] tri_mf(input logic [DW-1:0] v,
                                             input int a, input int b, input int c);
        logic [WP-1:0] vx, ax, bx, cx, mx, t;
        vx = WP'(v);
        ax = WP'(a);
        bx = WP'(b);
        cx = WP'(c);
        mx = WP'((1 << MW) - 1);
        t  = '0;
        if (vx > ax && vx <= bx) begin
            t = ((vx - ax) * mx) / (bx - ax);
        end else if (vx > bx && vx < cx) begin
            t = ((cx - vx) * mx) / (cx - bx);
        end
        return MW'(t);
    endfunction

    // Fuzzy AND: min for mode 0, scaled product for mode 1.
    function automatic logic [MW-1:0] and_op(input logic [MW-1:0] x,
                                             input logic [MW-1:0] y,
                                             input logic m);
        logic [2*MW-1:0] p;
        p = (2*MW)'(x) * (2*MW)'(y);
        if (m) begin
            return MW'(p >> MW);
        end
        return (x < y) ? x : y;
    endfunction

    assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
    assign div_last = (state_q == S_DIV) && (cnt_q == '0);

    // Numerator cannot overflow: three strengths times MW-bit weights < 2^(2MW+2).
    assign num   = NW'(s_hi_q) * NW'(W_HI) + NW'(s_md_q) * NW'(W_MD) + NW'(s_lo_q) * NW'(W_LO);
    assign trial = {rem_q, nsh_q[MW-1]};
    assign qbit  = (trial >= {1'b0, den_q});

    // Next-state and handshake flags; ready/valid are registered from the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FUZZ;
            S_FUZZ:  state_d = S_RULE;
            S_RULE:  state_d = S_ACCUM;
            S_ACCUM: state_d = S_DIV;
            S_DIV:   if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // Datapath: each stage updates only its own registers, everything else holds.
    always_comb begin
        rain_d    = rain_q;
        soil_d    = soil_q;
        mode_d    = mode_q;
        rain_lo_d = rain_lo_q;
        rain_md_d = rain_md_q;
        rain_hi_d = rain_hi_q;
        soil_lo_d = soil_lo_q;
        soil_md_d = soil_md_q;
        soil_hi_d = soil_hi_q;
        s_lo_d    = s_lo_q;
        s_md_d    = s_md_q;
        s_hi_d    = s_hi_q;
        den_d     = den_q;
        rem_d     = rem_q;
        nsh_d     = nsh_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        risk_d    = risk_q;
        no_rule_d = no_rule_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rain_d = rain;
                    soil_d = soil;
                    mode_d = and_mode;
                end
            end
            S_FUZZ: begin
                rain_lo_d = tri_mf(rain_q, LO_A, LO_B, LO_C);
                rain_md_d = tri_mf(rain_q, MD_A, MD_B, MD_C);
                rain_hi_d = tri_mf(rain_q, HI_A, HI_B, HI_C);
                soil_lo_d = tri_mf(soil_q, LO_A, LO_B, LO_C);
                soil_md_d = tri_mf(soil_q, MD_A, MD_B, MD_C);
                soil_hi_d = tri_mf(soil_q, HI_A, HI_B, HI_C);
            end
            S_RULE: begin
                s_lo_d = and_op(rain_lo_q, soil_lo_q, mode_q);
                s_md_d = and_op(rain_md_q, soil_md_q, mode_q);
                s_hi_d = and_op(rain_hi_q, soil_hi_q, mode_q);
            end
            S_ACCUM: begin
                // The quotient is bounded by the largest weight, so the upper
                // bits of the numerator are already below den and seed the remainder.
                den_d = DNW'(s_hi_q) + DNW'(s_md_q) + DNW'(s_lo_q);
                rem_d = num[NW-1:MW];
                nsh_d = num[MW-1:0];
                quo_d = '0;
                cnt_d = CW'(MW - 1);
            end
            S_DIV: begin
                rem_d = qbit ? DNW'(trial - {1'b0, den_q}) : trial[DNW-1:0];
                nsh_d = {nsh_q[MW-2:0], 1'b0};
                quo_d = {quo_q[MW-2:0], qbit};
                if (div_last) begin
                    risk_d    = (den_q == '0) ? '0 : {quo_q[MW-2:0], qbit};
                    no_rule_d = (den_q == '0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // State and pipeline registers; reset discards any in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rain_q      <= '0;
            soil_q      <= '0;
            mode_q      <= 1'b0;
            rain_lo_q   <= '0;
            rain_md_q   <= '0;
            rain_hi_q   <= '0;
            soil_lo_q   <= '0;
            soil_md_q   <= '0;
            soil_hi_q   <= '0;
            s_lo_q      <= '0;
            s_md_q      <= '0;
            s_hi_q      <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            nsh_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            risk_q      <= '0;
            no_rule_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rain_q      <= rain_d;
            soil_q      <= soil_d;
            mode_q      <= mode_d;
            rain_lo_q   <= rain_lo_d;
            rain_md_q   <= rain_md_d;
            rain_hi_q   <= rain_hi_d;
            soil_lo_q   <= soil_lo_d;
            soil_md_q   <= soil_md_d;
            soil_hi_q   <= soil_hi_d;
            s_lo_q      <= s_lo_d;
            s_md_q      <= s_md_d;
            s_hi_q      <= s_hi_d;
            den_q       <= den_d;
            rem_q       <= rem_d;
            nsh_q       <= nsh_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            risk_q      <= risk_d;
            no_rule_q   <= no_rule_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign risk      = risk_q;
    assign no_rule   = no_rule_q;

endmodule

// File: tb/tb_fuzzy_risk_engine.sv
// Scoreboard bench for fuzzy_risk_engine: the driver pushes the reference
// result for every accepted sample, the monitor pops and compares whenever
// the DUT presents a result.

module tb_fuzzy_risk_engine;

    localparam int DW   = 8;
    localparam int MW   = 8;
    localparam int MAXV = (1 << MW) - 1;
    localparam int LAT  = MW + 3;
    localparam int TPUT = MW + 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] rain;
    logic [DW-1:0] soil;
    logic          and_mode;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] risk;
    logic          no_rule;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int exp_risk_q[$];
    int exp_nr_q[$];
    int acc_q[$];
    bit seen = 1'b0;
    int prev_acc = -1;

    fuzzy_risk_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rain      (rain),
        .soil      (soil),
        .and_mode  (and_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .risk      (risk),
        .no_rule   (no_rule)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, straight from the set/rule/centroid definitions.
    function automatic int tri_m(input int v, input int a, input int b, input int c);
        if (v <= a || v >= c) return 0;
        if (v <= b) return (v - a) * MAXV / (b - a);
        return (c - v) * MAXV / (c - b);
    endfunction

    function automatic int and_m(input int x, input int y, input int m);
        if (m != 0) return (x * y) / (1 << MW);
        return (x < y) ? x : y;
    endfunction

    task automatic model(input int r, input int s, input int m, output int rk, output int nr);
        int lo, md, hi, den;
        lo  = and_m(tri_m(r, 0, 20, 40),  tri_m(s, 0, 20, 40),  m);
        md  = and_m(tri_m(r, 30, 50, 70), tri_m(s, 30, 50, 70), m);
        hi  = and_m(tri_m(r, 60, 80, 100), tri_m(s, 60, 80, 100), m);
        den = lo + md + hi;
        if (den == 0) begin
            rk = 0;
            nr = 1;
        end else begin
            rk = (lo * 85 + md * 170 + hi * 255) / den;
            nr = 0;
        end
    endtask

    task automatic push_expect(input int r, input int s, input int m);
        int rk, nr;
        model(r, s, m, rk, nr);
        exp_risk_q.push_back(rk);
        exp_nr_q.push_back(nr);
        acc_q.push_back(cyc + 1);
    endtask

    // Monitor: compare on every valid cycle (also proves hold stability), pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_risk_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 expected=0 (t=%0t)", $time);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - acc_q[0], LAT);
                    seen = 1'b1;
                end
                chk("risk", int'(risk), exp_risk_q[0]);
                chk("no_rule", int'(no_rule), exp_nr_q[0]);
                if (out_ready) begin
                    void'(exp_risk_q.pop_front());
                    void'(exp_nr_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Drive one sample and hold it until accepted; optionally check back-to-back spacing.
    task automatic send(input int r, input int s, input int m, input bit tp);
        int n;
        @(posedge clk);
        #1;
        rain     = DW'(r);
        soil     = DW'(s);
        and_mode = m[0];
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        push_expect(r, s, m);
        if (tp && prev_acc >= 0) chk("throughput", (cyc + 1) - prev_acc, TPUT);
        prev_acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rain     = DW'($urandom);
        soil     = DW'($urandom);
        and_mode = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_risk_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("drain_timeout", exp_risk_q.size(), 0);
                exp_risk_q.delete();
                exp_nr_q.delete();
                acc_q.delete();
                seen = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        rain      = '0;
        soil      = '0;
        and_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_risk", int'(risk), 0);
        chk("rst_no_rule", int'(no_rule), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Directed points.
        send(20, 20, 0, 1'b0);
        wait_idle();
        send(80, 80, 0, 1'b0);
        send(50, 50, 0, 1'b1);
        send(35, 35, 0, 1'b1);
        send(35, 35, 1, 1'b1);
        send(0, 0, 0, 1'b1);
        send(20, 80, 0, 1'b1);
        send(255, 200, 1, 1'b1);
        wait_idle();

        // Backpressure: result held, second sample not taken while busy.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(80, 80, 0, 1'b0);
        @(posedge clk);
        #1;
        rain     = 8'd50;
        soil     = 8'd50;
        and_mode = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        if (in_ready) push_expect(50, 50, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Asynchronous reset five cycles into DIV.
        send(80, 80, 0, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_risk", int'(risk), 0);
        chk("midrst_no_rule", int'(no_rule), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        exp_risk_q.delete();
        exp_nr_q.delete();
        acc_q.delete();
        seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send(50, 50, 0, 1'b0);
        wait_idle();

        // Randomized samples, with occasional gaps between them.
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 110)), int'($urandom_range(0, 110)),
                 int'($urandom_range(0, 1)), 1'b0);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
